// File: rtl/parking_pkg.sv
// Shared types and constants for the parking access scheduler.
package parking_pkg;

    localparam int unsigned TOKEN_W    = 3;
    localparam int unsigned MAX_GATES  = 8;
    localparam int unsigned GATE_IDX_W = 3;
    localparam logic [3:0]  P_SLOT_NIBBLE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT    = 3'd1,
        ST_VERIFIED = 3'd2,
        ST_WRITE    = 3'd3,
        ST_TRAP     = 3'd4
    } state_e;

    function automatic logic [MAX_GATES-1:0] onehot_gate(input logic [GATE_IDX_W-1:0] idx);
        onehot_gate      = '0;
        onehot_gate[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_access_scheduler.sv
// Round-robin scheduler sharing one token-check / P-Q time-register write path among entry gates.
// Optional GATE_LOCKOUT_EN: per-gate consecutive-fail lockout exposed on gate_locked.
module parking_access_scheduler
    import parking_pkg::*;
#(
    parameter int unsigned NUM_GATES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_GATES-1:0]         gate_req,
    input  logic [NUM_GATES-1:0]         gate_confirm,
    input  logic [TOKEN_W*NUM_GATES-1:0] gate_token,
    input  logic [TOKEN_W-1:0]           system_token,
    input  logic [7:0]                   time_data,
    output logic [NUM_GATES-1:0]         gate_grant,
    output logic                         P_register_enable,
    output logic                         Q_register_enable,
    output logic [NUM_GATES-1:0]         gate_ok,
    output logic [NUM_GATES-1:0]         gate_fail,
    output logic                         busy
`ifdef GATE_LOCKOUT_EN
    ,
    output logic [NUM_GATES-1:0]         gate_locked
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_GATES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [NUM_GATES-1:0] gate_grant_q, gate_grant_d;
    logic                 p_en_q, p_en_d;
    logic                 q_en_q, q_en_d;
    logic [NUM_GATES-1:0] gate_ok_q, gate_ok_d;
    logic [NUM_GATES-1:0] gate_fail_q, gate_fail_d;
    logic                 busy_q, busy_d;

    logic [NUM_GATES-1:0] eligible_c;
    logic [NUM_GATES-1:0] arb_grant_c;
    logic [IDX_W-1:0]     arb_idx_c;
    logic                 arb_valid_c;
    logic [TOKEN_W-1:0]   tok_arr [NUM_GATES];
    logic [NUM_GATES-1:0] cur_onehot;
    logic [TMO_W-1:0]     tmo_inc;
    logic                 tmo_hit;
    logic                 cur_req, cur_cfm, release_grant;
    logic                 unused_c;

`ifdef GATE_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    logic [FAIL_W-1:0]    fail_cnt_q [NUM_GATES];
    logic [FAIL_W-1:0]    fail_cnt_d [NUM_GATES];
    logic [NUM_GATES-1:0] locked_q, locked_d;

    // Consecutive-fail count per gate; a locked gate stays masked until reset.
    always_comb begin
        for (int i = 0; i < int'(NUM_GATES); i++) begin
            fail_cnt_d[i] = fail_cnt_q[i];
            if (gate_ok_d[i]) begin
                fail_cnt_d[i] = '0;
            end else if (gate_fail_d[i] && (fail_cnt_q[i] != FAIL_W'(MAX_FAILS))) begin
                fail_cnt_d[i] = fail_cnt_q[i] + FAIL_W'(1);
            end
            locked_d[i] = (fail_cnt_d[i] >= FAIL_W'(MAX_FAILS));
        end
    end

    assign eligible_c  = gate_req & ~locked_q;
    assign gate_locked = locked_q;
    assign unused_c    = ^time_data[3:0];
`else
    assign eligible_c  = gate_req;
    assign unused_c    = ^{time_data[3:0], 32'(MAX_FAILS)};
`endif

    rr_arbiter #(
        .N     (NUM_GATES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (eligible_c),
        .ptr   (ptr_q),
        .grant (arb_grant_c),
        .idx   (arb_idx_c),
        .valid (arb_valid_c)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_GATES); i++) begin
            tok_arr[i] = gate_token[i*TOKEN_W +: TOKEN_W];
        end
    end

    // Next-state, counters and registered output values.
    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        tmo_d         = tmo_q;
        gate_grant_d  = gate_grant_q;
        p_en_d        = 1'b0;
        q_en_d        = 1'b0;
        gate_ok_d     = '0;
        gate_fail_d   = '0;
        release_grant = 1'b0;

        cur_req    = gate_req[grant_idx_q];
        cur_cfm    = gate_confirm[grant_idx_q];
        cur_onehot = NUM_GATES'(onehot_gate(GATE_IDX_W'(grant_idx_q)));
        tmo_inc    = (tmo_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TMO_W'(1);
        tmo_hit    = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

        case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    state_d      = ST_GRANT;
                    grant_idx_d  = arb_idx_c;
                    gate_grant_d = arb_grant_c;
                    tmo_d        = '0;
                end
            end
            ST_GRANT: begin
                if (!cur_req) begin
                    release_grant = 1'b1;
                end else if (cur_cfm) begin
                    if (tok_arr[grant_idx_q] == system_token) begin
                        state_d = ST_VERIFIED;
                        tmo_d   = '0;
                    end else begin
                        state_d     = ST_TRAP;
                        gate_fail_d = cur_onehot;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        release_grant = 1'b1;
                        gate_fail_d   = cur_onehot;
                    end
                end
            end
            ST_VERIFIED: begin
                if (!cur_req) begin
                    release_grant = 1'b1;
                end else if (cur_cfm) begin
                    state_d   = ST_WRITE;
                    tmo_d     = '0;
                    gate_ok_d = cur_onehot;
                    if (time_data[7:4] == P_SLOT_NIBBLE) begin
                        p_en_d = 1'b1;
                    end else begin
                        q_en_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        release_grant = 1'b1;
                        gate_fail_d   = cur_onehot;
                    end
                end
            end
            ST_WRITE: begin
                release_grant = 1'b1;
            end
            ST_TRAP: begin
                if (!cur_req) begin
                    release_grant = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                gate_grant_d = '0;
            end
        endcase

        // Every release advances the pointer past the served gate.
        if (release_grant) begin
            state_d      = ST_IDLE;
            gate_grant_d = '0;
            ptr_d        = (grant_idx_q == IDX_W'(NUM_GATES - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_idx_q  <= '0;
            ptr_q        <= '0;
            tmo_q        <= '0;
            gate_grant_q <= '0;
            p_en_q       <= 1'b0;
            q_en_q       <= 1'b0;
            gate_ok_q    <= '0;
            gate_fail_q  <= '0;
            busy_q       <= 1'b0;
`ifdef GATE_LOCKOUT_EN
            for (int i = 0; i < int'(NUM_GATES); i++) begin
                fail_cnt_q[i] <= '0;
            end
            locked_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            ptr_q        <= ptr_d;
            tmo_q        <= tmo_d;
            gate_grant_q <= gate_grant_d;
            p_en_q       <= p_en_d;
            q_en_q       <= q_en_d;
            gate_ok_q    <= gate_ok_d;
            gate_fail_q  <= gate_fail_d;
            busy_q       <= busy_d;
`ifdef GATE_LOCKOUT_EN
            fail_cnt_q   <= fail_cnt_d;
            locked_q     <= locked_d;
`endif
        end
    end

    assign gate_grant        = gate_grant_q;
    assign P_register_enable = p_en_q;
    assign Q_register_enable = q_en_q;
    assign gate_ok           = gate_ok_q;
    assign gate_fail         = gate_fail_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_parking_access_scheduler.sv
// Directed bench for parking_access_scheduler; pulse events are checked against a scoreboard queue.
// Build with +define+GATE_LOCKOUT_EN to include the lockout scenario.
module tb_parking_access_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  gate_req;
    logic [3:0]  gate_confirm;
    logic [11:0] gate_token;
    logic [2:0]  system_token;
    logic [7:0]  time_data;
    logic [3:0]  gate_grant;
    logic        P_register_enable;
    logic        Q_register_enable;
    logic [3:0]  gate_ok;
    logic [3:0]  gate_fail;
    logic        busy;
`ifdef GATE_LOCKOUT_EN
    logic [3:0]  gate_locked;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] exp_q [$];

    parking_access_scheduler #(
        .NUM_GATES      (4),
        .TIMEOUT_CYCLES (64),
        .MAX_FAILS      (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .gate_req          (gate_req),
        .gate_confirm      (gate_confirm),
        .gate_token        (gate_token),
        .system_token      (system_token),
        .time_data         (time_data),
        .gate_grant        (gate_grant),
        .P_register_enable (P_register_enable),
        .Q_register_enable (Q_register_enable),
        .gate_ok           (gate_ok),
        .gate_fail         (gate_fail),
        .busy              (busy)
`ifdef GATE_LOCKOUT_EN
        ,
        .gate_locked       (gate_locked)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int g);
        oh = 4'(1 << g);
    endfunction

    // Event word: {P, Q, gate_ok, gate_fail, gate_grant}
    function automatic logic [13:0] ev(input logic p, input logic q, input logic [3:0] ok,
                                       input logic [3:0] fl, input logic [3:0] gr);
        ev = {p, q, ok, fl, gr};
    endfunction

    task automatic confirm(input int g);
        gate_confirm = oh(g);
        @(negedge clock);
        gate_confirm = '0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        gate_req     = '0;
        gate_confirm = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Every cycle carrying a strobe must match the next queued event.
    always @(negedge clock) begin
        if (!reset && (P_register_enable || Q_register_enable || (|gate_ok) || (|gate_fail))) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({P_register_enable, Q_register_enable, gate_ok, gate_fail, gate_grant}), 32'(0));
            end else begin
                chk("pulse_event", 32'({P_register_enable, Q_register_enable, gate_ok, gate_fail, gate_grant}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset        = 1'b1;
        gate_req     = '0;
        gate_confirm = '0;
        gate_token   = {3'b101, 3'b101, 3'b101, 3'b101};
        system_token = 3'b101;
        time_data    = 8'hF0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({gate_grant, P_register_enable, Q_register_enable, gate_ok, gate_fail, busy}), 32'(0));
        reset = 1'b0;
        @(negedge clock);

        // Gate 1, good token, P slot
        gate_req = 4'b0010;
        @(negedge clock);
        chk("t1_grant", 32'(gate_grant), 32'(4'b0010));
        chk("t1_busy", 32'(busy), 32'(1));
        confirm(1);
        chk("t1_verified_grant", 32'(gate_grant), 32'(4'b0010));
        exp_q.push_back(ev(1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010));
        confirm(1);
        gate_req = '0;
        @(negedge clock);
        chk("t1_release", 32'({gate_grant, busy}), 32'(0));

        // Gate 1 again, Q slot
        time_data = 8'h70;
        gate_req  = 4'b0010;
        @(negedge clock);
        chk("t2_grant", 32'(gate_grant), 32'(4'b0010));
        confirm(1);
        exp_q.push_back(ev(1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010));
        confirm(1);
        gate_req = '0;
        @(negedge clock);
        chk("t2_release", 32'({gate_grant, busy}), 32'(0));

        // Gate 2, wrong token -> trap held until request drops
        gate_token[8:6] = 3'b011;
        gate_req = 4'b0100;
        @(negedge clock);
        chk("t3_grant", 32'(gate_grant), 32'(4'b0100));
        exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0100));
        confirm(2);
        repeat (3) @(negedge clock);
        chk("t3_trap_hold", 32'({gate_grant, busy}), 32'({4'b0100, 1'b1}));
        gate_req = '0;
        @(negedge clock);
        chk("t3_release", 32'({gate_grant, busy}), 32'(0));
        gate_token[8:6] = 3'b101;

        // All gates requesting: strict rotation 0,1,2,3,0
        do_reset();
        time_data = 8'hF5;
        gate_req  = 4'b1111;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_grant_%0d", i), 32'(gate_grant), 32'(oh(i % 4)));
            confirm(i % 4);
            exp_q.push_back(ev(1'b1, 1'b0, oh(i % 4), 4'b0000, oh(i % 4)));
            confirm(i % 4);
            @(negedge clock);
            chk($sformatf("t4_gap_%0d", i), 32'(gate_grant), 32'(0));
            @(negedge clock);
        end
        gate_req = '0;
        @(negedge clock);
        chk("t4_idle", 32'({gate_grant, busy}), 32'(0));

        // Timeout after 64 idle granted cycles, then async reset mid-VERIFIED
        do_reset();
        gate_req = 4'b0001;
        @(negedge clock);
        chk("t5_grant", 32'(gate_grant), 32'(4'b0001));
        exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000));
        n = 0;
        while (gate_fail === 4'b0000 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("t5_timeout_cycles", 32'(n), 32'(64));
        @(negedge clock);
        chk("t5_regrant", 32'(gate_grant), 32'(4'b0001));
        confirm(0);
        chk("t5_verified_busy", 32'({gate_grant, busy}), 32'({4'b0001, 1'b1}));
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_reset", 32'({gate_grant, P_register_enable, Q_register_enable, gate_ok, gate_fail, busy}), 32'(0));
        gate_req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

`ifdef GATE_LOCKOUT_EN
        // Gate 0 fails three times and is locked out; gate 3 is still served
        gate_token[2:0] = 3'b000;
        for (int i = 0; i < 3; i++) begin
            gate_req = 4'b0001;
            @(negedge clock);
            chk($sformatf("t6_grant_%0d", i), 32'(gate_grant), 32'(4'b0001));
            exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001));
            confirm(0);
            gate_req = '0;
            @(negedge clock);
        end
        chk("t6_locked", 32'(gate_locked), 32'(4'b0001));
        gate_req = 4'b0001;
        repeat (3) @(negedge clock);
        chk("t6_ignored", 32'({gate_grant, busy}), 32'(0));
        gate_req = 4'b1001;
        @(negedge clock);
        chk("t6_gate3_grant", 32'(gate_grant), 32'(4'b1000));
        confirm(3);
        exp_q.push_back(ev(1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1000));
        confirm(3);
        gate_req = '0;
        repeat (2) @(negedge clock);
        chk("t6_still_locked", 32'(gate_locked), 32'(4'b0001));
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
